// File: rtl/set_req_arbiter.sv
// N-channel set-index request arbiter with round-robin or fixed priority, burst locking
// and a registered ready/valid output stage.
module set_req_arbiter #(
    parameter int N     = 4,
    parameter int SET_W = 9,
    parameter int RR    = 1,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N-1:0]         io_in_valid,
    output logic [N-1:0]         io_in_ready,
    input  logic [N*SET_W-1:0]   io_in_bits_set,
    input  logic [N-1:0]         io_in_bits_last,
    output logic                 io_out_valid,
    input  logic                 io_out_ready,
    output logic [SET_W-1:0]     io_out_bits_set,
    output logic [IDX_W-1:0]     io_out_chosen
);

    logic             vld_p1;
    logic [SET_W-1:0] set_p1;
    logic [IDX_W-1:0] chosen_p1;
    logic [IDX_W-1:0] ptr;
    logic             lock;
    logic [IDX_W-1:0] lock_idx;

    logic [N-1:0]     grant;
    logic             en;
    logic             fire;
    logic [IDX_W-1:0] sel_idx;
    logic [SET_W-1:0] sel_set;
    logic             sel_last;
    logic [IDX_W-1:0] ptr_nxt;
    int               best;
    int               win;

    // Scan position of channel i relative to the round-robin base; lower wins.
    function automatic int scan_dist(input int i, input logic [IDX_W-1:0] p);
        if (RR == 0) return i;
        return (i >= int'(p)) ? i - int'(p) : i + N - int'(p);
    endfunction

    // ---- stage p0: arbitration and handshake (combinational) ----
    always_comb begin
        grant = '0;
        best  = N;
        win   = 0;
        for (int i = 0; i < N; i++) begin
            if (lock) begin
                if (IDX_W'(i) == lock_idx) grant[i] = io_in_valid[i];
            end else if (io_in_valid[i] && (scan_dist(i, ptr) < best)) begin
                best = scan_dist(i, ptr);
                win  = i;
            end
        end
        if (!lock && (best < N)) begin
            for (int i = 0; i < N; i++) begin
                if (i == win) grant[i] = 1'b1;
            end
        end
    end

    always_comb begin
        sel_idx  = '0;
        sel_set  = '0;
        sel_last = 1'b0;
        ptr_nxt  = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                sel_idx  = IDX_W'(i);
                sel_set  = io_in_bits_set[i*SET_W +: SET_W];
                sel_last = io_in_bits_last[i];
                ptr_nxt  = (i == N - 1) ? '0 : IDX_W'(i + 1);
            end
        end
    end

    // Reset gates the accept path so no handshake completes while state is being cleared.
    assign en          = (~vld_p1 | io_out_ready) & ~reset;
    assign fire        = en & (|grant);
    assign io_in_ready = grant & {N{en}};

    // ---- stage p1: output register, lock and pointer state ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_p1    <= 1'b0;
            set_p1    <= '0;
            chosen_p1 <= '0;
            ptr       <= '0;
            lock      <= 1'b0;
            lock_idx  <= '0;
        end else begin
            if (en) begin
                vld_p1 <= fire;
                if (fire) begin
                    set_p1    <= sel_set;
                    chosen_p1 <= sel_idx;
                end
            end
            if (fire) begin
                if (!sel_last) begin
                    lock     <= 1'b1;
                    lock_idx <= sel_idx;
                end else begin
                    lock <= 1'b0;
                    if (RR != 0) ptr <= ptr_nxt;
                end
            end
        end
    end

    assign io_out_valid    = vld_p1;
    assign io_out_bits_set = set_p1;
    assign io_out_chosen   = chosen_p1;

endmodule

// File: tb/tb_set_req_arbiter.sv
// Bench for set_req_arbiter: three instances (RR N=4, fixed N=4, RR N=3) driven by directed
// and random stimulus, compared every cycle against a scan-order reference model.
module tb_set_req_arbiter;

    logic clock;
    logic reset;

    logic [3:0] sv[3];
    logic [8:0] sset[3][4];
    logic [3:0] slast[3];
    logic       sordy[3];

    logic [35:0] set0, set1;
    logic [26:0] set2;
    assign set0 = {sset[0][3], sset[0][2], sset[0][1], sset[0][0]};
    assign set1 = {sset[1][3], sset[1][2], sset[1][1], sset[1][0]};
    assign set2 = {sset[2][2], sset[2][1], sset[2][0]};

    logic [3:0] rdy0, rdy1;
    logic [2:0] rdy2;
    logic       ov0, ov1, ov2;
    logic [8:0] os0, os1, os2;
    logic [1:0] oc0, oc1, oc2;

    set_req_arbiter #(.N(4), .SET_W(9), .RR(1)) dut_rr (
        .clock(clock), .reset(reset), .io_in_valid(sv[0]), .io_in_ready(rdy0),
        .io_in_bits_set(set0), .io_in_bits_last(slast[0]), .io_out_valid(ov0),
        .io_out_ready(sordy[0]), .io_out_bits_set(os0), .io_out_chosen(oc0));

    set_req_arbiter #(.N(4), .SET_W(9), .RR(0)) dut_fp (
        .clock(clock), .reset(reset), .io_in_valid(sv[1]), .io_in_ready(rdy1),
        .io_in_bits_set(set1), .io_in_bits_last(slast[1]), .io_out_valid(ov1),
        .io_out_ready(sordy[1]), .io_out_bits_set(os1), .io_out_chosen(oc1));

    set_req_arbiter #(.N(3), .SET_W(9), .RR(1)) dut_n3 (
        .clock(clock), .reset(reset), .io_in_valid(sv[2][2:0]), .io_in_ready(rdy2),
        .io_in_bits_set(set2), .io_in_bits_last(slast[2][2:0]), .io_out_valid(ov2),
        .io_out_ready(sordy[2]), .io_out_bits_set(os2), .io_out_chosen(oc2));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Reference model state, one slot per instance
    int         m_ptr[3];
    int         m_owner[3];
    bit         m_lock[3];
    bit         m_ov[3];
    logic [8:0] m_oset[3];
    int         m_och[3];

    function automatic int nch(input int d);
        return (d == 2) ? 3 : 4;
    endfunction

    function automatic bit is_rr(input int d);
        return d != 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_ptr[d] = 0; m_owner[d] = 0; m_lock[d] = 0;
            m_ov[d] = 0; m_oset[d] = '0; m_och[d] = 0;
        end
    endtask

    // Channel that would be granted now, or -1
    function automatic int winner(input int d);
        int n = nch(d);
        if (m_lock[d]) return sv[d][m_owner[d]] ? m_owner[d] : -1;
        for (int k = 0; k < n; k++) begin
            int c = is_rr(d) ? (m_ptr[d] + k) % n : k;
            if (sv[d][c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready(input int d);
        int w = winner(d);
        bit en = !m_ov[d] || sordy[d];
        if (reset) return 4'b0;
        return (en && w >= 0) ? 4'(1 << w) : 4'b0;
    endfunction

    task automatic model_step();
        for (int d = 0; d < 3; d++) begin
            int w = winner(d);
            bit en = !m_ov[d] || sordy[d];
            bit fire = en && (w >= 0);
            if (en) m_ov[d] = fire;
            if (fire) begin
                m_oset[d] = sset[d][w];
                m_och[d]  = w;
                if (!slast[d][w]) begin
                    m_lock[d] = 1; m_owner[d] = w;
                end else begin
                    m_lock[d] = 0;
                    if (is_rr(d)) m_ptr[d] = (w + 1) % nch(d);
                end
            end
        end
    endtask

    task automatic check_dut(input int d);
        logic [3:0] r; logic v; logic [8:0] s; logic [1:0] c;
        case (d)
            0:       begin r = rdy0;         v = ov0; s = os0; c = oc0; end
            1:       begin r = rdy1;         v = ov1; s = os1; c = oc1; end
            default: begin r = {1'b0, rdy2}; v = ov2; s = os2; c = oc2; end
        endcase
        chk($sformatf("d%0d_ready", d), r, exp_ready(d));
        chk($sformatf("d%0d_out_valid", d), v, m_ov[d]);
        chk($sformatf("d%0d_out_set", d), s, m_oset[d]);
        chk($sformatf("d%0d_out_chosen", d), c, m_och[d]);
    endtask

    // Called right after a falling edge with inputs already driven; returns at the next falling edge
    task automatic cycle();
        #1;
        for (int d = 0; d < 3; d++) check_dut(d);
        @(posedge clock);
        if (!reset) model_step();
        @(negedge clock);
    endtask

    task automatic idle();
        for (int d = 0; d < 3; d++) begin
            sv[d] = '0; slast[d] = 4'hF; sordy[d] = 1'b1;
            for (int i = 0; i < 4; i++) sset[d][i] = '0;
        end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        model_reset();
        @(negedge clock);
        cycle();
        reset = 1'b0;
        chk("reset_out_valid", ov0, 0);
        cycle(); cycle();
        chk("idle_out_valid", ov0, 0);

        // Round-robin fairness, all four valid
        sv[0] = 4'hF;
        for (int i = 0; i < 4; i++) sset[0][i] = 9'h010 + 9'(i);
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("rr_chosen", oc0, k % 4);
            chk("rr_set", os0, 9'h010 + 9'(k % 4));
        end
        idle(); cycle();

        // Fixed priority: channel 1 beats channel 3
        sv[1] = 4'b1010; sset[1][1] = 9'h1A5; sset[1][3] = 9'h003;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("fp_chosen", oc1, 1);
            chk("fp_set", os1, 9'h1A5);
        end
        sv[1] = 4'b1000;
        cycle();
        chk("fp_chosen_ch3", oc1, 3);
        chk("fp_set_ch3", os1, 9'h003);
        idle(); cycle();

        // Burst lock: move ptr to 2, then ch2 bursts while ch0 keeps requesting
        sv[0] = 4'b0010; cycle();
        sv[0] = 4'b0101; slast[0] = 4'b1011; sset[0][0] = 9'h001; sset[0][2] = 9'h0C0;
        #1 chk("lock_beat0_ready", rdy0, 4'b0100);
        cycle();
        chk("lock_beat0_chosen", oc0, 2);
        sv[0] = 4'b0001;
        #1 chk("lock_gap_ready", rdy0, 4'b0000);
        cycle();
        chk("lock_gap_valid", ov0, 0);
        sv[0] = 4'b0101; sset[0][2] = 9'h0C1;
        #1 chk("lock_beat1_ready", rdy0, 4'b0100);
        cycle();
        chk("lock_beat1_set", os0, 9'h0C1);
        slast[0] = 4'b1111; sset[0][2] = 9'h0C2;
        #1 chk("lock_beat2_ready", rdy0, 4'b0100);
        cycle();
        chk("lock_beat2_set", os0, 9'h0C2);
        #1 chk("unlock_ready", rdy0, 4'b0001);
        cycle();
        chk("unlock_chosen", oc0, 0);
        chk("unlock_set", os0, 9'h001);
        idle(); cycle();

        // Backpressure holds the output and blocks all inputs
        sv[0] = 4'b0010; sset[0][1] = 9'h0AB;
        cycle();
        chk("bp_first_set", os0, 9'h0AB);
        sordy[0] = 1'b0; sset[0][1] = 9'h055;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("bp_hold_set", os0, 9'h0AB);
            chk("bp_hold_valid", ov0, 1);
            chk("bp_hold_ready", rdy0, 4'b0000);
        end
        sordy[0] = 1'b1;
        #1 chk("bp_release_ready", rdy0, 4'b0010);
        cycle();
        chk("bp_release_set", os0, 9'h055);
        idle(); cycle();

        // Wrap-around with N=3
        sv[2] = 4'b0010; cycle();
        sv[2] = 4'b0011;
        #1 chk("wrap_ready", rdy2, 3'b001);
        cycle();
        chk("wrap_chosen", oc2, 0);
        #1 chk("wrap_next_ready", rdy2, 3'b010);
        cycle();
        chk("wrap_next_chosen", oc2, 1);
        idle(); cycle();

        // Asynchronous reset in the middle of a locked burst with a held output
        sv[0] = 4'b0010; slast[0] = 4'b1101; sordy[0] = 1'b0;
        cycle();
        chk("pre_rst_valid", ov0, 1);
        #2 reset = 1'b1;
        model_reset();
        #1;
        chk("rst_out_valid", ov0, 0);
        chk("rst_ready", rdy0, 4'b0000);
        chk("rst_out_set", os0, 0);
        chk("rst_out_chosen", oc0, 0);
        cycle();
        reset = 1'b0;
        idle();
        cycle(); cycle();
        chk("post_rst_idle", ov0, 0);
        sv[0] = 4'b1001;
        #1 chk("post_rst_ready", rdy0, 4'b0001);
        cycle();
        chk("post_rst_chosen", oc0, 0);
        idle(); cycle();

        // Random traffic against the model
        for (int t = 0; t < 400; t++) begin
            for (int d = 0; d < 3; d++) begin
                sv[d] = 4'($urandom_range(0, 15));
                if (d == 2) sv[d][3] = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    sset[d][i] = 9'($urandom_range(0, 511));
                    slast[d][i] = ($urandom_range(0, 2) != 0);
                end
                sordy[d] = ($urandom_range(0, 3) != 0);
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
